// File: rtl/alu_wb_stage.sv
// Execute->writeback pipeline register behind the SPARC V8 ALU.
// Holds one result entry, owns the architectural icc and evaluates Bicc conditions.
module alu_wb_stage #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RD_W      = 5,
  parameter logic [3:0]  ICC_RESET = 4'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_op,
  input  logic [DATA_W-1:0] in_res,
  input  logic              in_n,
  input  logic              in_z,
  input  logic              in_v,
  input  logic              in_c,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_res,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_we,
  output logic              out_illegal,
  output logic [3:0]        icc,
  output logic              alu_cin,
  input  logic              icc_wr_en,
  input  logic [3:0]        icc_wdata,
  input  logic [3:0]        cond,
  output logic              cond_true
);

  localparam int unsigned ICC_N = 3;
  localparam int unsigned ICC_Z = 2;
  localparam int unsigned ICC_V = 1;
  localparam int unsigned ICC_C = 0;

  logic accept;
  logic op_ok;
  logic op_cc;

  // Opcode decode: groups 0x0_/0x1_ share the same low-nibble map, 0x2_ has three ops.
  always_comb begin
    op_ok = 1'b0;
    case (in_op[5:4])
      2'b00, 2'b01: op_ok = (in_op[3:0] <= 4'd8) || (in_op[3:0] == 4'hC);
      2'b10:        op_ok = (in_op[3:0] >= 4'd5) && (in_op[3:0] <= 4'd7);
      default:      op_ok = 1'b0;
    endcase
  end

  assign op_cc    = op_ok && (in_op[5:4] == 2'b01);
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign alu_cin  = icc[ICC_C];

  // Single-entry writeback register; accept overrides pop for full-rate streaming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_res     <= '0;
      out_rd      <= '0;
      out_we      <= 1'b0;
      out_illegal <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_res     <= in_res;
      out_rd      <= in_rd;
      out_we      <= op_ok && (in_rd != '0);
      out_illegal <= !op_ok;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  // icc commits at the accept edge so a following ADDX/SUBX sees the new carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icc <= ICC_RESET;
    end else if (icc_wr_en) begin
      icc <= icc_wdata;
    end else if (accept && op_cc) begin
      icc <= {in_n, in_z, in_v, in_c};
    end
  end

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'h0: cond_true = 1'b0;
      4'h1: cond_true = icc[ICC_Z];
      4'h2: cond_true = icc[ICC_Z] | (icc[ICC_N] ^ icc[ICC_V]);
      4'h3: cond_true = icc[ICC_N] ^ icc[ICC_V];
      4'h4: cond_true = icc[ICC_C] | icc[ICC_Z];
      4'h5: cond_true = icc[ICC_C];
      4'h6: cond_true = icc[ICC_N];
      4'h7: cond_true = icc[ICC_V];
      4'h8: cond_true = 1'b1;
      4'h9: cond_true = ~icc[ICC_Z];
      4'hA: cond_true = ~(icc[ICC_Z] | (icc[ICC_N] ^ icc[ICC_V]));
      4'hB: cond_true = ~(icc[ICC_N] ^ icc[ICC_V]);
      4'hC: cond_true = ~(icc[ICC_C] | icc[ICC_Z]);
      4'hD: cond_true = ~icc[ICC_C];
      4'hE: cond_true = ~icc[ICC_N];
      4'hF: cond_true = ~icc[ICC_V];
      default: cond_true = 1'b0;
    endcase
  end

endmodule
